// File: rtl/seg7_pkg.sv
`default_nettype none
// ============================================================================
// Module      : seg7_pkg
// Description : Shared types and active-low 7-segment patterns (bit 6 = a,
//               bit 0 = g) for the two-digit hex display link.
// Revision    : 1.0 - initial release
// ============================================================================
package seg7_pkg;

    typedef logic [6:0] seg_t;
    typedef logic [3:0] nibble_t;

    localparam seg_t SEG_0 = 7'b0000001;
    localparam seg_t SEG_1 = 7'b1001111;
    localparam seg_t SEG_2 = 7'b0010010;
    localparam seg_t SEG_3 = 7'b0000110;
    localparam seg_t SEG_4 = 7'b1001100;
    localparam seg_t SEG_5 = 7'b0100100;
    localparam seg_t SEG_6 = 7'b0100000;
    localparam seg_t SEG_7 = 7'b0001111;
    localparam seg_t SEG_8 = 7'b0000000;
    localparam seg_t SEG_9 = 7'b0000100;
    localparam seg_t SEG_A = 7'b0001000;
    localparam seg_t SEG_B = 7'b1100000;
    localparam seg_t SEG_C = 7'b0110001;
    localparam seg_t SEG_D = 7'b1000010;
    localparam seg_t SEG_E = 7'b0110000;
    localparam seg_t SEG_F = 7'b0111000;

endpackage
`default_nettype wire

// File: rtl/seg7_decode.sv
`default_nettype none
// ============================================================================
// Module      : seg7_decode
// Description : Combinational reverse lookup of a segment pattern to its hex
//               nibble; hit is low when the pattern is not a hex glyph.
// Revision    : 1.0 - initial release
// ============================================================================
module seg7_decode
    import seg7_pkg::*;
(
    input  seg_t    seg,
    output nibble_t nib,
    output logic    hit
);

    // Table lookup; unknown patterns report a miss with a zero nibble
    always_comb begin
        nib = 4'h0;
        hit = 1'b1;
        case (seg)
            SEG_0:   nib = 4'h0;
            SEG_1:   nib = 4'h1;
            SEG_2:   nib = 4'h2;
            SEG_3:   nib = 4'h3;
            SEG_4:   nib = 4'h4;
            SEG_5:   nib = 4'h5;
            SEG_6:   nib = 4'h6;
            SEG_7:   nib = 4'h7;
            SEG_8:   nib = 4'h8;
            SEG_9:   nib = 4'h9;
            SEG_A:   nib = 4'hA;
            SEG_B:   nib = 4'hB;
            SEG_C:   nib = 4'hC;
            SEG_D:   nib = 4'hD;
            SEG_E:   nib = 4'hE;
            SEG_F:   nib = 4'hF;
            default: hit = 1'b0;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/seg7_rx.sv
`default_nettype none
// ============================================================================
// Module      : seg7_rx
// Description : Receives the multiplexed two-digit 7-segment bus, filters it
//               for stability, decodes each digit and presents {hi, lo} on a
//               valid/ready output with sticky error flags.
// Revision    : 1.0 - initial release
// ============================================================================
module seg7_rx
    import seg7_pkg::*;
#(
    parameter int STABLE_CYCLES = 4,
    parameter int CNT_W         = $clog2(STABLE_CYCLES + 1)
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] seg_in,
    input  logic [1:0] dig_sel,
    output logic [7:0] out_data,
    output logic       out_valid,
    input  logic       out_ready,
    input  logic       clr,
    output logic       bad_seg,
    output logic       overrun
);

    localparam logic [CNT_W-1:0] c_cnt_max = CNT_W'(STABLE_CYCLES);
    localparam logic [CNT_W-1:0] c_cnt_cap = CNT_W'(STABLE_CYCLES - 1);

    logic [8:0]       r_smp;
    logic [CNT_W-1:0] r_cnt;
    nibble_t          r_lo;
    nibble_t          r_hi;
    logic             r_lo_vld;
    logic             r_hi_vld;
    logic [7:0]       r_out_data;
    logic             r_out_valid;
    logic             r_bad_seg;
    logic             r_overrun;

    logic [8:0] w_in;
    logic       w_same;
    logic       w_cap;
    nibble_t    w_nib;
    logic       w_hit;
    logic       w_cap_lo;
    logic       w_cap_hi;
    logic       w_err;
    logic       w_asm;
    logic       w_ovr;

    seg7_decode u_decode (
        .seg (seg_in),
        .nib (w_nib),
        .hit (w_hit)
    );

    assign w_in   = {dig_sel, seg_in};
    assign w_same = (w_in == r_smp);
    // Fires once on the last edge of a STABLE_CYCLES-long run of equal samples
    assign w_cap  = w_same && (r_cnt == c_cnt_cap);

    assign w_cap_lo = w_cap && (dig_sel == 2'b01) && w_hit;
    assign w_cap_hi = w_cap && (dig_sel == 2'b10) && w_hit;
    assign w_err    = w_cap && ((dig_sel == 2'b11) ||
                                ((dig_sel != 2'b00) && !w_hit));

    assign w_asm = r_lo_vld && r_hi_vld && (!r_out_valid || out_ready);
    // A recapture coinciding with assembly refills an emptied slot, not an overrun
    assign w_ovr = !w_asm && ((w_cap_lo && r_lo_vld) || (w_cap_hi && r_hi_vld));

    // Stability filter: restart the run on any change, saturate otherwise
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_smp <= '0;
            r_cnt <= '0;
        end else if (!w_same) begin
            r_smp <= w_in;
            r_cnt <= CNT_W'(1);
        end else if (r_cnt != c_cnt_max) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    // Nibble capture and pending flags; capture wins over assembly's clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lo     <= '0;
            r_hi     <= '0;
            r_lo_vld <= 1'b0;
            r_hi_vld <= 1'b0;
        end else begin
            if (w_cap_lo) begin
                r_lo     <= w_nib;
                r_lo_vld <= 1'b1;
            end else if (w_asm) begin
                r_lo_vld <= 1'b0;
            end
            if (w_cap_hi) begin
                r_hi     <= w_nib;
                r_hi_vld <= 1'b1;
            end else if (w_asm) begin
                r_hi_vld <= 1'b0;
            end
        end
    end

    // Output byte register with valid/ready handshake
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
        end else if (w_asm) begin
            r_out_data  <= {r_hi, r_lo};
            r_out_valid <= 1'b1;
        end else if (r_out_valid && out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    // Sticky error flags; a new error in the clear cycle wins
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bad_seg <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            if (w_err)
                r_bad_seg <= 1'b1;
            else if (clr)
                r_bad_seg <= 1'b0;
            if (w_ovr)
                r_overrun <= 1'b1;
            else if (clr)
                r_overrun <= 1'b0;
        end
    end

    assign out_data  = r_out_data;
    assign out_valid = r_out_valid;
    assign bad_seg   = r_bad_seg;
    assign overrun   = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_seg7_rx.sv
`default_nettype none
// ============================================================================
// Module      : tb_seg7_rx
// Description : Directed self-checking bench for seg7_rx.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seg7_rx;

    logic       clk;
    logic       rst_n;
    logic [6:0] seg_in;
    logic [1:0] dig_sel;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready;
    logic       clr;
    logic       bad_seg;
    logic       overrun;

    int n_chk;
    int n_bad;

    seg7_rx #(.STABLE_CYCLES(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .seg_in    (seg_in),
        .dig_sel   (dig_sel),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .clr       (clr),
        .bad_seg   (bad_seg),
        .overrun   (overrun)
    );

    // 10 ns clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Apply a digit for n rising edges; returns just after a falling edge
    task automatic drive(input logic [1:0] sel, input logic [6:0] seg, input int n);
        dig_sel = sel;
        seg_in  = seg;
        repeat (n) @(negedge clk);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        n_chk     = 0;
        n_bad     = 0;
        rst_n     = 1'b0;
        seg_in    = 7'b1111111;
        dig_sel   = 2'b00;
        out_ready = 1'b0;
        clr       = 1'b0;
        idle(2);
        chk("rst_data",  {24'd0, out_data}, 32'h00);
        chk("rst_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_bad",   {31'd0, bad_seg},  32'd0);
        chk("rst_ovr",   {31'd0, overrun},  32'd0);
        rst_n = 1'b1;
        idle(2);

        // Byte assembly: hi=A, lo=5
        drive(2'b10, 7'b0001000, 4);
        drive(2'b01, 7'b0100100, 4);
        chk("asm_lat", {31'd0, out_valid}, 32'd0);
        idle(1);
        chk("asm_valid", {31'd0, out_valid}, 32'd1);
        chk("asm_data",  {24'd0, out_data}, 32'hA5);
        chk("asm_bad",   {31'd0, bad_seg},  32'd0);
        idle(2);
        chk("asm_hold",  {31'd0, out_valid}, 32'd1);
        out_ready = 1'b1;
        idle(1);
        out_ready = 1'b0;
        chk("asm_pop",   {31'd0, out_valid}, 32'd0);

        // Glitch rejection: 5 held only 3 edges never captures
        drive(2'b01, 7'b0100100, 3);
        drive(2'b01, 7'b0001111, 4);
        drive(2'b10, 7'b0111000, 4);
        idle(1);
        chk("gl_data",  {24'd0, out_data}, 32'hF7);
        chk("gl_valid", {31'd0, out_valid}, 32'd1);
        chk("gl_ovr",   {31'd0, overrun},  32'd0);
        out_ready = 1'b1;
        idle(1);
        out_ready = 1'b0;

        // Backpressure: 0x12 held while 0x34 waits
        drive(2'b10, 7'b1001111, 4);
        drive(2'b01, 7'b0010010, 4);
        idle(1);
        chk("bp_first", {24'd0, out_data}, 32'h12);
        drive(2'b10, 7'b0000110, 4);
        drive(2'b01, 7'b1001100, 4);
        idle(2);
        chk("bp_stall", {24'd0, out_data}, 32'h12);
        chk("bp_stallv", {31'd0, out_valid}, 32'd1);
        out_ready = 1'b1;
        idle(1);
        out_ready = 1'b0;
        chk("bp_next",  {24'd0, out_data}, 32'h34);
        chk("bp_nextv", {31'd0, out_valid}, 32'd1);
        chk("bp_ovr",   {31'd0, overrun},  32'd0);
        out_ready = 1'b1;
        idle(1);
        out_ready = 1'b0;
        chk("bp_empty", {31'd0, out_valid}, 32'd0);

        // Invalid pattern, bad select, clear
        drive(2'b01, 7'b1111111, 4);
        chk("inv_bad",   {31'd0, bad_seg},  32'd1);
        idle(2);
        chk("inv_novld", {31'd0, out_valid}, 32'd0);
        clr = 1'b1;
        idle(1);
        clr = 1'b0;
        chk("inv_clr",   {31'd0, bad_seg},  32'd0);
        drive(2'b11, 7'b0000001, 4);
        chk("sel11_bad", {31'd0, bad_seg},  32'd1);
        clr = 1'b1;
        idle(1);
        clr = 1'b0;
        chk("sel11_clr", {31'd0, bad_seg},  32'd0);

        // Overrun: lo 3 then lo 9, then hi 0
        drive(2'b01, 7'b0000110, 4);
        chk("ov_pre",   {31'd0, overrun},  32'd0);
        drive(2'b01, 7'b0000100, 4);
        chk("ov_set",   {31'd0, overrun},  32'd1);
        drive(2'b10, 7'b0000001, 4);
        idle(1);
        chk("ov_data",  {24'd0, out_data}, 32'h09);
        chk("ov_valid", {31'd0, out_valid}, 32'd1);

        // Reset mid-operation with a byte pending, bad_seg set and hi pending
        drive(2'b01, 7'b1111111, 4);
        chk("rr_bad",   {31'd0, bad_seg},  32'd1);
        drive(2'b10, 7'b0100000, 4);
        dig_sel = 2'b01;
        seg_in  = 7'b1001111;
        #2;
        rst_n = 1'b0;
        #1;
        chk("rr_data",  {24'd0, out_data}, 32'h00);
        chk("rr_valid", {31'd0, out_valid}, 32'd0);
        chk("rr_bad0",  {31'd0, bad_seg},  32'd0);
        chk("rr_ovr0",  {31'd0, overrun},  32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        drive(2'b01, 7'b1001111, 4);
        idle(2);
        chk("rr_lone",  {31'd0, out_valid}, 32'd0);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/seg7_rx.md
Name: seg7_rx

Overview:
- Receiving end of the team's two-digit hex 7-segment interface. It samples the multiplexed segment lines, a 7-bit active-low pattern plus a digit select, and filters them for stability.
- Each stable pattern is decoded back to a 4-bit nibble. The high and low nibbles are assembled into a byte, which is presented on a valid/ready output.
- Used for display loop-back checking and for reading segment outputs from LFSR/counter demos back into test logic.

Parameters:
- STABLE_CYCLES, 4: consecutive identical samples required before a digit is captured. Minimum 2.
- CNT_W, $clog2(STABLE_CYCLES+1): width of the stability counter. Derived; do not override.

Ports:
- clk  in  1  single clock; all state on the rising edge.
- rst_n  in  1  reset, asynchronous assert, active-low.
- seg_in  in  7  segment pattern, active-low. Bit 6 = a, bit 0 = g.
- dig_sel  in  2  one-hot digit select: [0] = low nibble, [1] = high nibble, 00 = blank.
- out_data  out  8  assembled byte, {hi, lo}.
- out_valid  out  1  out_data holds an unconsumed byte.
- out_ready  in  1  consumer accepts the byte when out_valid && out_ready.
- clr  in  1  synchronous clear of the sticky flags.
- bad_seg  out  1  sticky: an invalid pattern or dig_sel=11 was captured.
- overrun  out  1  sticky: a digit was recaptured before its previous nibble was used.

Behaviour:
- Reset (async, rst_n=0): all registers clear.
  - out_data=0, out_valid=0, bad_seg=0, overrun=0.
  - smp=0, cnt=0, lo_vld=0, hi_vld=0.
- Stability filter. smp holds {dig_sel, seg_in}. At each edge:
  - if the input differs from smp: smp<=input, cnt<=1;
  - otherwise cnt increments, saturating at STABLE_CYCLES.
- Capture fires at an edge where the input equals smp and cnt==STABLE_CYCLES-1. A pattern held across STABLE_CYCLES consecutive edges therefore captures exactly once, on the last of those edges. It does not recapture until the input changes.
- Capture actions:
  - dig_sel=00: no action.
  - dig_sel=01: lo<=decode(seg_in), lo_vld<=1.
  - dig_sel=10: hi<=decode(seg_in), hi_vld<=1.
  - dig_sel=11: bad_seg<=1; nibble registers untouched.
  - Pattern not in the decode table: bad_seg<=1; that nibble and its flag are unchanged.
  - Valid pattern captured while its flag is already 1: nibble overwritten (latest wins), overrun<=1.
- Assembly. When lo_vld && hi_vld && (!out_valid || out_ready) at an edge:
  - out_data<={hi, lo}, out_valid<=1, lo_vld<=0, hi_vld<=0.
  - Latency: out_valid is high one edge after the second digit's capture edge.
- A capture in the same edge as assembly: the assembly uses the old nibbles, and the new digit sets its flag again. The capture wins over the clear; overrun is not set.
- Handshake:
  - out_valid && out_ready with no new assembly: out_valid<=0.
  - out_data is stable while out_valid && !out_ready.
  - Accept and reload can occur in the same edge, giving back-to-back bytes.
- clr=1: bad_seg<=0 and overrun<=0, unless a new error is set in the same edge; set wins.
- Reset mid-operation discards any partial digit and any pending byte.

Decomposition:
- Package seg7_pkg holds:
  - typedef seg_t (7-bit) and nibble_t (4-bit);
  - the 16 pattern constants SEG_0..SEG_F: 0000001, 1001111, 0010010, 0000110, 1001100, 0100100, 0100000, 0001111, 0000000, 0000100, 0001000, 1100000, 0110001, 1000010, 0110000, 0111000.
- One sub-module, seg7_decode: purely combinational, seg_t in, nibble_t out plus a hit flag. The hit flag drives bad_seg.

Test Plan:
- Byte assembly: hold seg=0001000 (A), sel=10 for 4 cycles, then seg=0100100 (5), sel=01 for 4 cycles → out_data=0xA5, out_valid=1 one edge after the 8th edge; bad_seg=0.
- Glitch rejection: sel=01 with pattern 5 for 3 cycles, then 7 (0001111) for 4 cycles, then sel=10 with F for 4 cycles → out_data=0xF7; no capture of 5.
- Backpressure: out_ready=0 while 0x12 and then digits for 0x34 arrive → out_data stays 0x12. Raise out_ready for 1 cycle → next edge out_data=0x34, out_valid stays 1.
- Invalid pattern and bad select: seg=1111111 with sel=01 held 4 cycles → bad_seg=1, no byte. sel=11 → bad_seg stays 1. Pulse clr → bad_seg=0.
- Overrun: low digit 3 then low digit 9 before any high digit, then high digit 0 → overrun=1, out_data=0x09.
- Reset: assert rst_n=0 asynchronously mid-pattern with hi_vld=1 → all outputs 0 immediately. After release, a low digit alone produces no byte.
